adc_multi_capture: RTL and testbench

Multi-channel, trigger-driven ADC capture sequencer. It sits between the per-channel float-conversion AXI-Stream outputs and a single-beat DDR write master, and replaces the single-channel trigger/address logic. Each channel gets a one-entry holding buffer, and buffers are served round-robin. The block supports single-shot and continuous re-arm modes and raises a completion interrupt.

---
 rtl/adc_cap_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/adc_multi_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_adc_multi_capture.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the multi-channel ADC capture sequencer.
package adc_cap_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } cap_state_t;

   // DDR byte address of sample idx in channel ch; wraps silently at 2^32.
   function automatic logic [31:0] ch_addr(input logic [31:0] base,
                                           input logic [31:0] ch_off,
                                           input logic [31:0] ch,
                                           input logic [31:0] idx,
                                           input logic [31:0] stride);
      return base + ch * ch_off + idx * stride;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; the last-grant pointer lives in the parent.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IW-1:0]     last_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic              valid_o
);

   always_comb begin
      int c;
      c       = 0;
      grant_o = '0;
      valid_o = 1'b0;
      // Search starts one past the last grant and wraps back onto it.
      for (int k = 1; k <= NUM_CH; k++) begin
         c = (int'(last_i) + k) % NUM_CH;
         if (!valid_o && req_i[c]) begin
            grant_o[c] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_multi_capture.sv
// Trigger-driven multi-channel ADC capture: one-entry buffer per channel,
// round-robin single-beat DDR writes, single-shot or continuous re-arm.
//
// state   | meaning
// IDLE    | waiting for i_arm
// ARMED   | waiting for falling edge on i_beam_trg
// CAPTURE | buffering samples and writing them out
// DRAIN   | abort: let the outstanding write finish, then drop buffers
// DONE    | one-cycle completion, raises o_done_irq
module adc_multi_capture
   import adc_cap_pkg::*;
#(
   parameter int          NUM_CH        = 4,
   parameter int          DATA_WIDTH    = 32,
   parameter int          MEM_SIZE      = 10000,
   parameter logic [31:0] DDR_OFFSET    = 32'h0,
   parameter logic [31:0] DDR_CH_OFFSET = 32'h1000_0000,
   localparam int         CNT_W         = $clog2(MEM_SIZE) + 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_arm,
   input  logic                         i_abort,
   input  logic                         i_mode,
   input  logic [CNT_W-1:0]             i_sample_cnt,
   input  logic                         i_beam_trg,
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_CH-1:0]            s_axis_tvalid,
   output logic [NUM_CH-1:0]            s_axis_tready,
   output logic [31:0]                  o_wr_addr,
   output logic [DATA_WIDTH-1:0]        o_wr_data,
   output logic                         o_wr_valid,
   input  logic                         i_wr_ready,
   input  logic                         i_wr_done,
   output logic                         o_busy,
   output logic                         o_done_irq,
   output logic                         o_overflow,
   output logic [STATE_W-1:0]           o_state
);

   localparam int               IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [31:0]      STRIDE  = 32'(DATA_WIDTH / 8);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   cap_state_t            state_q, state_d;
   logic                  trg_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]         last_q, last_d, wr_ch_q, wr_ch_d, gnt_idx;
   logic                  wr_valid_q, wr_valid_d, wr_pend_q, wr_pend_d;
   logic                  overflow_q, overflow_d;
   logic [31:0]           wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   logic                  in_cap, trig, wr_busy, wr_fin, cap_start, clr_bufs;
   logic [NUM_CH-1:0]     full_v, done_v, ovf_v, arb_gnt;
   logic                  arb_valid;
   logic [CNT_W-1:0]      idx_v [NUM_CH];
   logic [DATA_WIDTH-1:0] buf_v [NUM_CH];

   assign in_cap  = (state_q == ST_CAPTURE);
   assign trig    = trg_q & ~i_beam_trg;
   assign wr_busy = wr_valid_q | wr_pend_q;
   assign wr_fin  = wr_pend_q & i_wr_done;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic                  full_q, full_d, done_q, done_d, load, wr_hit;
      logic [CNT_W-1:0]      idx_q, idx_d, idx_inc;
      logic [DATA_WIDTH-1:0] buf_q, buf_d;

      // Outside CAPTURE the stream is accepted and dropped so upstream never stalls.
      assign s_axis_tready[g] = in_cap ? ~(full_q | done_q) : 1'b1;
      assign load     = in_cap & s_axis_tvalid[g] & ~full_q & ~done_q;
      assign ovf_v[g] = in_cap & s_axis_tvalid[g] & full_q & ~done_q;
      assign wr_hit   = wr_fin & (wr_ch_q == IW'(g));
      assign idx_inc  = idx_q + CNT_ONE;

      always_comb begin
         full_d = full_q;
         done_d = done_q;
         idx_d  = idx_q;
         buf_d  = buf_q;
         if (cap_start) begin
            full_d = 1'b0;
            done_d = 1'b0;
            idx_d  = '0;
         end else if (clr_bufs) begin
            full_d = 1'b0;
         end else begin
            if (load) begin
               full_d = 1'b1;
               buf_d  = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
            end
            if (wr_hit) begin
               full_d = 1'b0;
               idx_d  = idx_inc;
               if (idx_inc == cnt_q) done_d = 1'b1;
            end
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            full_q <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            buf_q  <= '0;
         end else begin
            full_q <= full_d;
            done_q <= done_d;
            idx_q  <= idx_d;
            buf_q  <= buf_d;
         end
      end

      assign full_v[g] = full_q;
      assign done_v[g] = done_q;
      assign idx_v[g]  = idx_q;
      assign buf_v[g]  = buf_q;
   end

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req_i   (full_v),
      .last_i  (last_q),
      .grant_o (arb_gnt),
      .valid_o (arb_valid)
   );

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (arb_gnt[k]) gnt_idx = IW'(k);
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      wr_valid_d = wr_valid_q;
      wr_pend_d  = wr_pend_q;
      wr_ch_d    = wr_ch_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      overflow_d = overflow_q | (|ovf_v);
      cap_start  = 1'b0;
      clr_bufs   = 1'b0;

      if (wr_valid_q && i_wr_ready) begin
         wr_valid_d = 1'b0;
         wr_pend_d  = 1'b1;
      end
      if (wr_fin) wr_pend_d = 1'b0;

      if (in_cap && !wr_busy && arb_valid) begin
         wr_valid_d = 1'b1;
         wr_ch_d    = gnt_idx;
         last_d     = gnt_idx;
         wr_addr_d  = ch_addr(DDR_OFFSET, DDR_CH_OFFSET, 32'(gnt_idx),
                              32'(idx_v[gnt_idx]), STRIDE);
         wr_data_d  = buf_v[gnt_idx];
      end

      case (state_q)
         ST_IDLE: begin
            if (i_arm) begin
               state_d    = ST_ARMED;
               overflow_d = 1'b0;
            end
         end
         ST_ARMED: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (trig) begin
               cnt_d     = i_sample_cnt;
               cap_start = 1'b1;
               state_d   = (i_sample_cnt == '0) ? ST_DONE : ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (i_abort)      state_d = ST_DRAIN;
            else if (&done_v) state_d = ST_DONE;
         end
         ST_DRAIN: begin
            if (!wr_busy || wr_fin) begin
               clr_bufs = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_DONE: begin
            state_d = (i_abort || !i_mode) ? ST_IDLE : ST_ARMED;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         trg_q      <= 1'b1;
         cnt_q      <= '0;
         last_q     <= '0;
         wr_ch_q    <= '0;
         wr_valid_q <= 1'b0;
         wr_pend_q  <= 1'b0;
         overflow_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         trg_q      <= i_beam_trg;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         wr_ch_q    <= wr_ch_d;
         wr_valid_q <= wr_valid_d;
         wr_pend_q  <= wr_pend_d;
         overflow_q <= overflow_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign o_wr_addr  = wr_addr_q;
   assign o_wr_data  = wr_data_q;
   assign o_wr_valid = wr_valid_q;
   assign o_busy     = (state_q != ST_IDLE);
   assign o_done_irq = (state_q == ST_DONE);
   assign o_overflow = overflow_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_adc_multi_capture.sv
// Directed bench for adc_multi_capture with a queue-based write-order model.
module tb_adc_multi_capture;

   localparam int NCH = 2;
   localparam int DW  = 32;
   localparam int CW  = $clog2(10000) + 1;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_arm = 1'b0;
   logic              i_abort = 1'b0;
   logic              i_mode = 1'b0;
   logic [CW-1:0]     i_sample_cnt = '0;
   logic              i_beam_trg = 1'b1;
   logic [NCH*DW-1:0] s_axis_tdata = '0;
   logic [NCH-1:0]    s_axis_tvalid = '0;
   logic [NCH-1:0]    s_axis_tready;
   logic [31:0]       o_wr_addr;
   logic [DW-1:0]     o_wr_data;
   logic              o_wr_valid;
   logic              i_wr_ready;
   logic              i_wr_done;
   logic              o_busy, o_done_irq, o_overflow;
   logic [2:0]        o_state;

   adc_multi_capture #(.NUM_CH(NCH), .DATA_WIDTH(DW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_arm(i_arm), .i_abort(i_abort),
      .i_mode(i_mode), .i_sample_cnt(i_sample_cnt), .i_beam_trg(i_beam_trg),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
      .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .i_wr_done(i_wr_done),
      .o_busy(o_busy), .o_done_irq(o_done_irq), .o_overflow(o_overflow),
      .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] d;
      int          ch;
      int          c;
   } samp_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          rdy_dly = 0;
   int          done_dly = 3;
   bit          model_en = 1'b0;
   int          mlast = 0;
   int          midx [NCH];
   int          irq_cnt = 0;
   samp_t       mq [$];
   logic [31:0] wr_log [$];
   logic [31:0] exp_ss [6] = '{32'h0, 32'h1000_0000, 32'h4, 32'h1000_0004,
                               32'h8, 32'h1000_0008};
   logic [31:0] exp_cont [4] = '{32'h0, 32'h1000_0000, 32'h0, 32'h1000_0000};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge i_clk) cyc <= cyc + 1;

   // Write slave: ready after rdy_dly cycles, done pulse done_dly cycles later.
   initial begin
      i_wr_ready = 1'b0;
      i_wr_done  = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_wr_valid && !i_rst) begin
            repeat (rdy_dly) @(negedge i_clk);
            i_wr_ready = 1'b1;
            @(negedge i_clk);
            i_wr_ready = 1'b0;
            repeat (done_dly - 1) @(negedge i_clk);
            i_wr_done = 1'b1;
            @(negedge i_clk);
            i_wr_done = 1'b0;
         end
      end
   end

   // Expected grant: first channel after the previous grant holding a sample
   // that was loaded before the edge where o_wr_valid rose.
   task automatic model_write();
      int pick = -1;
      int c;
      for (int k = 1; k <= NCH && pick < 0; k++) begin
         c = (mlast + k) % NCH;
         for (int j = 0; j < mq.size(); j++) begin
            if (pick < 0 && mq[j].ch == c && mq[j].c < cyc) pick = j;
         end
      end
      if (pick < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_write: got addr %0h expected no write", o_wr_addr);
      end else begin
         c = mq[pick].ch;
         check("wr_addr", 64'(o_wr_addr), 64'(32'(c) * 32'h1000_0000 + 32'(midx[c]) * 32'd4));
         check("wr_data", 64'(o_wr_data), 64'(mq[pick].d));
         midx[c]++;
         mlast = c;
         mq.delete(pick);
      end
   endtask

   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   always @(negedge i_clk) begin
      if (!i_rst) begin
         check("busy_vs_state", 64'(o_busy), 64'(o_state != 3'd0));
         check("irq_vs_state", 64'(o_done_irq), 64'(o_state == 3'd4));
         if (o_state != 3'd2) check("tready_not_capture", 64'(s_axis_tready), 64'(2'b11));
         if (o_done_irq) irq_cnt++;
         if (o_wr_valid && prev_valid && !prev_ready) begin
            check("addr_stable", 64'(o_wr_addr), 64'(prev_addr));
            check("data_stable", 64'(o_wr_data), 64'(prev_data));
         end
         if (o_wr_valid && !prev_valid) begin
            wr_log.push_back(o_wr_addr);
            if (model_en) model_write();
         end
      end
      prev_valid = i_rst ? 1'b0 : o_wr_valid;
      prev_ready = i_wr_ready;
      prev_addr  = o_wr_addr;
      prev_data  = o_wr_data;
   end

   task automatic pulse(input int ch, input logic [31:0] d, input bit exp_rdy);
      @(posedge i_clk);
      #1;
      s_axis_tdata[ch*DW +: DW] = d;
      s_axis_tvalid[ch] = 1'b1;
      check($sformatf("tready_ch%0d", ch), 64'(s_axis_tready[ch]), 64'(exp_rdy));
      if (exp_rdy && model_en) mq.push_back('{d, ch, cyc + 1});
      @(posedge i_clk);
      #1;
      s_axis_tvalid[ch] = 1'b0;
   endtask

   task automatic round(input logic [31:0] d0, input logic [31:0] d1);
      pulse(0, d0, 1'b1);
      repeat (4) @(posedge i_clk);
      pulse(1, d1, 1'b1);
   endtask

   task automatic arm();
      @(negedge i_clk) i_arm = 1'b1;
      @(negedge i_clk) i_arm = 1'b0;
   endtask

   task automatic abort();
      @(negedge i_clk) i_abort = 1'b1;
      @(negedge i_clk) i_abort = 1'b0;
   endtask

   task automatic trigger();
      @(negedge i_clk);
      i_beam_trg = 1'b0;
      mq.delete();
      foreach (midx[i]) midx[i] = 0;
      @(negedge i_clk);
      i_beam_trg = 1'b1;
   endtask

   task automatic wait_state(input logic [2:0] st, input int limit, input string name);
      int n = 0;
      while (o_state !== st && n < limit) begin
         @(negedge i_clk);
         n++;
      end
      check(name, 64'(o_state), 64'(st));
   endtask

   task automatic wait_valid(input int limit, input string name);
      int n = 0;
      while (o_wr_valid !== 1'b1 && n < limit) begin
         @(negedge i_clk);
         n++;
      end
      check(name, 64'(o_wr_valid), 64'(1'b1));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"}, 64'(o_state), 64'(0));
      check({tag, "_busy"}, 64'(o_busy), 64'(0));
      check({tag, "_irq"}, 64'(o_done_irq), 64'(0));
      check({tag, "_ovf"}, 64'(o_overflow), 64'(0));
      check({tag, "_valid"}, 64'(o_wr_valid), 64'(0));
      check({tag, "_addr"}, 64'(o_wr_addr), 64'(0));
      check({tag, "_data"}, 64'(o_wr_data), 64'(0));
      check({tag, "_tready"}, 64'(s_axis_tready), 64'(2'b11));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge i_clk);
      check_reset("reset");
      i_rst = 1'b0;

      // single-shot, 3 samples per channel
      model_en = 1'b1;
      i_mode = 1'b0;
      i_sample_cnt = 15'd3;
      wr_log.delete();
      irq_cnt = 0;
      arm();
      check("ss_armed", 64'(o_state), 64'(1));
      trigger();
      check("ss_capture", 64'(o_state), 64'(2));
      for (int r = 0; r < 3; r++) begin
         if (r > 0) repeat (14) @(posedge i_clk);
         round(32'hA000_0000 + 32'(r), 32'hB000_0000 + 32'(r));
      end
      wait_state(3'd4, 200, "ss_done");
      @(negedge i_clk);
      check("ss_idle", 64'(o_state), 64'(0));
      check("ss_nwr", 64'(wr_log.size()), 64'(6));
      for (int i = 0; i < 6 && i < wr_log.size(); i++)
         check($sformatf("ss_addr%0d", i), 64'(wr_log[i]), 64'(exp_ss[i]));
      check("ss_irq", 64'(irq_cnt), 64'(1));

      // continuous re-arm, 1 sample per channel, two triggers
      wr_log.delete();
      irq_cnt = 0;
      i_mode = 1'b1;
      i_sample_cnt = 15'd1;
      arm();
      for (int t = 0; t < 2; t++) begin
         trigger();
         check("cont_capture", 64'(o_state), 64'(2));
         round(32'h5500_0000 + 32'(t), 32'h6600_0000 + 32'(t));
         wait_state(3'd4, 200, "cont_done");
         @(negedge i_clk);
         check("cont_rearm", 64'(o_state), 64'(1));
      end
      check("cont_nwr", 64'(wr_log.size()), 64'(4));
      for (int i = 0; i < 4 && i < wr_log.size(); i++)
         check($sformatf("cont_addr%0d", i), 64'(wr_log[i]), 64'(exp_cont[i]));
      check("cont_irq", 64'(irq_cnt), 64'(2));
      abort();
      check("armed_abort", 64'(o_state), 64'(0));
      i_mode = 1'b0;

      // overflow while the only write is held for 100 cycles
      model_en = 1'b0;
      irq_cnt = 0;
      i_sample_cnt = 15'd2;
      done_dly = 100;
      arm();
      trigger();
      pulse(0, 32'hC0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         repeat (8) @(posedge i_clk);
         pulse(0, 32'hC1 + 32'(i), 1'b0);
      end
      check("ovf_set", 64'(o_overflow), 64'(1));
      done_dly = 3;
      repeat (70) @(posedge i_clk);
      pulse(0, 32'hC8, 1'b1);
      repeat (10) @(posedge i_clk);
      pulse(1, 32'hD0, 1'b1);
      repeat (10) @(posedge i_clk);
      pulse(1, 32'hD1, 1'b1);
      wait_state(3'd4, 100, "ovf_done");
      @(negedge i_clk);
      check("ovf_idle", 64'(o_state), 64'(0));
      check("ovf_sticky", 64'(o_overflow), 64'(1));
      check("ovf_irq", 64'(irq_cnt), 64'(1));
      arm();
      check("ovf_clear", 64'(o_overflow), 64'(0));
      abort();

      // abort with a write outstanding
      model_en = 1'b1;
      irq_cnt = 0;
      done_dly = 40;
      arm();
      trigger();
      pulse(0, 32'hE0, 1'b1);
      wait_valid(20, "abort_wr_valid");
      repeat (5) @(negedge i_clk);
      abort();
      check("abort_drain", 64'(o_state), 64'(3));
      repeat (10) @(negedge i_clk);
      check("drain_hold", 64'(o_state), 64'(3));
      wait_state(3'd0, 100, "drain_idle");
      @(negedge i_clk);
      check("abort_irq", 64'(irq_cnt), 64'(0));
      check("abort_tready", 64'(s_axis_tready), 64'(2'b11));
      done_dly = 3;

      // zero sample count
      wr_log.delete();
      irq_cnt = 0;
      i_sample_cnt = '0;
      arm();
      trigger();
      check("zero_done", 64'(o_state), 64'(4));
      check("zero_irq_pulse", 64'(o_done_irq), 64'(1));
      @(negedge i_clk);
      check("zero_idle", 64'(o_state), 64'(0));
      repeat (5) @(negedge i_clk);
      check("zero_nwr", 64'(wr_log.size()), 64'(0));
      check("zero_irq", 64'(irq_cnt), 64'(1));

      // reset while o_wr_valid is high
      rdy_dly = 20;
      i_sample_cnt = 15'd1;
      arm();
      trigger();
      pulse(0, 32'hF0, 1'b1);
      wait_valid(20, "rst_wr_valid");
      i_rst = 1'b1;
      @(negedge i_clk);
      check_reset("midwr");
      i_rst = 1'b0;
      rdy_dly = 0;
      mlast = 0;
      trigger();
      check("rst_trg_ignored", 64'(o_state), 64'(0));
      repeat (40) @(negedge i_clk);
      check("rst_still_idle", 64'(o_state), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
